instruction_loader: RTL and testbench

//  Upstream feeder of the IF stage: turns a byte stream from the debug UART receiver into

---
 rtl/instruction_loader.sv | 113 +++++++++++
 tb/tb_instruction_loader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
// Assembles little-endian bytes from the debug UART into instruction words and writes them
// sequentially into the IF instruction memory, ending the load on the HALT word.
module instruction_loader #(
    parameter int WORD_SIZE_IN_BYTES = 4,
    parameter int BYTE_SIZE          = 8,
    parameter int MEM_SIZE_IN_WORDS  = 64,
    parameter logic [WORD_SIZE_IN_BYTES*BYTE_SIZE-1:0] HALT_INSTR = 32'hFFFFFFFF
) (
    input  logic                                    i_clk,
    input  logic                                    i_reset,
    input  logic                                    i_start,
    input  logic                                    i_rx_valid,
    input  logic [BYTE_SIZE-1:0]                    i_rx_data,
    input  logic                                    i_full_mem,
    output logic                                    o_clear_mem,
    output logic                                    o_write_mem,
    output logic [WORD_SIZE_IN_BYTES*BYTE_SIZE-1:0] o_instruction,
    output logic                                    o_busy,
    output logic                                    o_done,
    output logic                                    o_error,
    output logic [$clog2(MEM_SIZE_IN_WORDS):0]      o_words_loaded
);

    localparam int IDX_W = (WORD_SIZE_IN_BYTES > 1) ? $clog2(WORD_SIZE_IN_BYTES) : 1;
    localparam int CNT_W = $clog2(MEM_SIZE_IN_WORDS) + 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RECV,
        WRITE,
        DONE,
        ERROR
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state          <= IDLE;
            idx            <= '0;
            o_clear_mem    <= 1'b0;
            o_write_mem    <= 1'b0;
            o_instruction  <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_error        <= 1'b0;
            o_words_loaded <= '0;
        end else begin
            o_clear_mem <= 1'b0;
            o_write_mem <= 1'b0;
            o_done      <= 1'b0;
            // Start wins over everything, including a byte arriving in the same cycle.
            if (i_start) begin
                state          <= CLEAR;
                idx            <= '0;
                o_clear_mem    <= 1'b1;
                o_busy         <= 1'b1;
                o_error        <= 1'b0;
                o_words_loaded <= '0;
                o_done         <= (state == DONE);
            end else begin
                case (state)
                    IDLE: begin
                    end
                    CLEAR: begin
                        state <= RECV;
                    end
                    RECV: begin
                        if (i_rx_valid) begin
                            o_instruction[idx*BYTE_SIZE +: BYTE_SIZE] <= i_rx_data;
                            if (idx == IDX_W'(WORD_SIZE_IN_BYTES - 1)) begin
                                idx   <= '0;
                                state <= WRITE;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end
                    end
                    WRITE: begin
                        if (i_full_mem) begin
                            o_error <= 1'b1;
                            o_busy  <= 1'b0;
                            state   <= ERROR;
                        end else begin
                            o_write_mem <= 1'b1;
                            if (o_words_loaded != CNT_W'(MEM_SIZE_IN_WORDS))
                                o_words_loaded <= o_words_loaded + CNT_W'(1);
                            if (o_instruction == HALT_INSTR) begin
                                o_busy <= 1'b0;
                                state  <= DONE;
                            end else begin
                                state <= RECV;
                            end
                        end
                    end
                    DONE: begin
                        o_done <= 1'b1;
                        state  <= IDLE;
                    end
                    ERROR: begin
                    end
                    default: begin
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: stimulus queues expected writes/pulses, a negedge
// monitor pops and compares whenever the DUT presents a clear, write or done pulse.
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        full_mem = 1'b0;
    logic        clear_mem;
    logic        write_mem;
    logic [31:0] instruction;
    logic        busy;
    logic        done;
    logic        error;
    logic [6:0]  words_loaded;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_wr_cyc = -100;
    int exp_clr = 0;
    int exp_done = 0;
    logic [38:0] wr_q[$];

    instruction_loader dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_start       (start),
        .i_rx_valid    (rx_valid),
        .i_rx_data     (rx_data),
        .i_full_mem    (full_mem),
        .o_clear_mem   (clear_mem),
        .o_write_mem   (write_mem),
        .o_instruction (instruction),
        .o_busy        (busy),
        .o_done        (done),
        .o_error       (error),
        .o_words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: each pulse must have been announced by the stimulus side.
    always @(negedge clk) begin
        cyc++;
        if (clear_mem) begin
            chk("clear_expected", 32'(exp_clr > 0), 32'd1);
            if (exp_clr > 0) exp_clr--;
            chk("clear_words_zero", 32'(words_loaded), 32'd0);
            chk("clear_error_zero", 32'(error), 32'd0);
        end
        if (write_mem) begin
            chk("write_expected", 32'(wr_q.size() > 0), 32'd1);
            if (wr_q.size() > 0) begin
                logic [38:0] e;
                e = wr_q.pop_front();
                chk("write_instruction", instruction, e[31:0]);
                chk("write_words_loaded", 32'(words_loaded), 32'(e[38:32]));
            end
            last_wr_cyc = cyc;
        end
        if (done) begin
            chk("done_expected", 32'(exp_done > 0), 32'd1);
            if (exp_done > 0) exp_done--;
            chk("done_after_write", 32'(cyc - last_wr_cyc), 32'd1);
            chk("done_busy_low", 32'(busy), 32'd0);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        exp_clr++;
        @(posedge clk); #1;
        start = 1'b0;
        idle(3);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        idle(10);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[k*8 +: 8]);
    endtask

    task automatic drained(input string name);
        idle(4);
        chk({name, "_writes_drained"}, 32'(wr_q.size()), 32'd0);
        chk({name, "_clears_drained"}, 32'(exp_clr), 32'd0);
        chk({name, "_done_drained"}, 32'(exp_done), 32'd0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_clear"}, 32'(clear_mem), 32'd0);
        chk({name, "_write"}, 32'(write_mem), 32'd0);
        chk({name, "_instr"}, instruction, 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_error"}, 32'(error), 32'd0);
        chk({name, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    initial begin
        // 1: reset state, then start gives a single clear pulse.
        rst = 1'b1;
        idle(3);
        chk_all_zero("reset");
        rst = 1'b0;
        idle(2);
        @(posedge clk); #1;
        start = 1'b1;
        exp_clr++;
        @(posedge clk); #1;
        start = 1'b0;
        chk("t1_clear_now", 32'(clear_mem), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_write", 32'(write_mem), 32'd0);
        @(posedge clk); #1;
        chk("t1_clear_one_cycle", 32'(clear_mem), 32'd0);
        idle(2);

        // 2: one word, little-endian assembly.
        wr_q.push_back({7'd1, 32'h12345678});
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        drained("t2");
        chk("t2_busy", 32'(busy), 32'd1);
        chk("t2_words", 32'(words_loaded), 32'd1);

        // 3: two words then HALT.
        pulse_start();
        wr_q.push_back({7'd1, 32'hDEADBEEF});
        send_word(32'hDEADBEEF);
        wr_q.push_back({7'd2, 32'h00000013});
        send_word(32'h00000013);
        wr_q.push_back({7'd3, 32'hFFFFFFFF});
        exp_done++;
        send_word(32'hFFFFFFFF);
        drained("t3");
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_words", 32'(words_loaded), 32'd3);

        // 4: memory full -> sticky error, cleared by a new start.
        pulse_start();
        full_mem = 1'b1;
        send_word(32'hA5A5A5A5);
        drained("t4");
        chk("t4_error", 32'(error), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_words", 32'(words_loaded), 32'd0);
        idle(20);
        chk("t4_error_held", 32'(error), 32'd1);
        full_mem = 1'b0;
        pulse_start();
        chk("t4_error_cleared", 32'(error), 32'd0);
        chk("t4_busy_again", 32'(busy), 32'd1);
        drained("t4b");

        // 5: async reset mid-word aborts with no write.
        send_byte(8'h01); send_byte(8'h02);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk_all_zero("t5_async");
        idle(2);
        rst = 1'b0;
        send_byte(8'h03); send_byte(8'h04);
        drained("t5");
        chk_all_zero("t5_after");

        // 6: restart mid-word discards the partial; start beats a same-cycle byte.
        pulse_start();
        send_byte(8'hAA); send_byte(8'hBB);
        @(posedge clk); #1;
        start = 1'b1; rx_valid = 1'b1; rx_data = 8'h99;
        exp_clr++;
        @(posedge clk); #1;
        start = 1'b0; rx_valid = 1'b0;
        idle(10);
        wr_q.push_back({7'd1, 32'h44332211});
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        drained("t6");
        chk("t6_words", 32'(words_loaded), 32'd1);

        // 7: word counter saturates at memory depth.
        pulse_start();
        for (int i = 0; i < 65; i++) begin
            wr_q.push_back({(i < 64) ? 7'(i + 1) : 7'd64, 32'h01000000 + 32'(i)});
            send_word(32'h01000000 + 32'(i));
        end
        drained("t7");
        chk("t7_words_saturated", 32'(words_loaded), 32'd64);
        chk("t7_busy", 32'(busy), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
